// File: rtl/gpio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : gpio_pkg                                                    |
// | Purpose  : Shared GPIO register map, decoded register selector and     |
// |            register-port access record. The GPIO output block and the  |
// |            bus decoder use these too.                                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package gpio_pkg;

  localparam int GPIO_REG_W = 32;

  // Byte offsets of the 32-bit registers
  localparam logic [7:0] GPIO_VALUE_OFS   = 8'h00;
  localparam logic [7:0] GPIO_RISE_EN_OFS = 8'h04;
  localparam logic [7:0] GPIO_FALL_EN_OFS = 8'h08;
  localparam logic [7:0] GPIO_STATUS_OFS  = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_EN_OFS  = 8'h10;

  typedef enum logic [2:0] {
    REG_SEL_NONE    = 3'd0,
    REG_SEL_VALUE   = 3'd1,
    REG_SEL_RISE_EN = 3'd2,
    REG_SEL_FALL_EN = 3'd3,
    REG_SEL_STATUS  = 3'd4,
    REG_SEL_IRQ_EN  = 3'd5
  } gpio_reg_sel_e;

  // One register-port access as seen by a slave in its request cycle
  typedef struct packed {
    logic                  we;
    logic [7:0]            addr;
    logic [GPIO_REG_W-1:0] wdata;
  } gpio_reg_access_t;

  // Full-offset match: misaligned or unmapped offsets select nothing
  function automatic gpio_reg_sel_e gpio_decode(input logic [7:0] ofs);
    gpio_reg_sel_e sel;
    case (ofs)
      GPIO_VALUE_OFS:   sel = REG_SEL_VALUE;
      GPIO_RISE_EN_OFS: sel = REG_SEL_RISE_EN;
      GPIO_FALL_EN_OFS: sel = REG_SEL_FALL_EN;
      GPIO_STATUS_OFS:  sel = REG_SEL_STATUS;
      GPIO_IRQ_EN_OFS:  sel = REG_SEL_IRQ_EN;
      default:          sel = REG_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_edge_capture_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: gpio_edge_capture_if                                        |
// | Purpose  : Single-cycle register port of the GPIO input block.         |
// | Signals  : reg_req   request, one cycle                                |
// |            reg_we    1 = write, 0 = read                               |
// |            reg_addr  byte address, word aligned                        |
// |            reg_wdata write data                                        |
// |            reg_rdata read data, valid with reg_ack                     |
// |            reg_ack   acknowledge, one cycle after reg_req              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface gpio_edge_capture_if
  import gpio_pkg::*;
#(
  parameter int ADDR_W = 5
);
  logic                  reg_req;
  logic                  reg_we;
  logic [ADDR_W-1:0]     reg_addr;
  logic [GPIO_REG_W-1:0] reg_wdata;
  logic [GPIO_REG_W-1:0] reg_rdata;
  logic                  reg_ack;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );
endinterface
`default_nettype wire

// File: rtl/gpio_debounce_cell.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : gpio_debounce_cell                                          |
// | Purpose  : One GPIO pin: synchroniser, debounce counter, stable flop   |
// |            and single-cycle rise/fall indications.                     |
// | Ports    : clock, reset_n  clock / async active-low reset              |
// |            pin_i           raw asynchronous pin                         |
// |            stable_o        debounced pin state                          |
// |            rise_o/fall_o   high in the cycle the stable flop is about  |
// |                            to change 0->1 / 1->0                        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module gpio_debounce_cell #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable_q;
  logic                   stable_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign stable_d = sync_out;
  end else begin : g_debounce
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how long sync has disagreed with stable; any
    // agreement restarts it, so only an unbroken run is accepted.
    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_out != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = sync_out;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end

  // Edges are taken from the pending update so the status flop can latch
  // on the same clock edge that moves the stable flop.
  assign rise_o   = ~stable_q &  stable_d;
  assign fall_o   =  stable_q & ~stable_d;
  assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/gpio_edge_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : gpio_edge_capture                                           |
// | Purpose  : GPIO input block. Debounces every pin, latches enabled      |
// |            rising/falling edges into sticky write-1-to-clear status    |
// |            and raises one registered level interrupt.                  |
// | Ports    : clock, reset_n  clock / async active-low reset              |
// |            gpio_input      raw pins                                     |
// |            bus             register port (slave side)                   |
// |            gpio_value      debounced pin state                          |
// |            irq             |(STATUS & IRQ_EN), registered              |
// | Registers: 0x00 VALUE RO, 0x04 RISE_EN, 0x08 FALL_EN,                  |
// |            0x0C STATUS RO/W1C, 0x10 IRQ_EN                             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module gpio_edge_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    gpio_input,
  gpio_edge_capture_if.slave  bus,
  output logic [WIDTH-1:0]    gpio_value,
  output logic                irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clock    (clock),
      .reset_n  (reset_n),
      .pin_i    (gpio_input[i]),
      .stable_o (stable[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

  // ---------------- register port decode ----------------
  logic [ADDR_W-1:0] addr;
  logic              addr_in_range;
  gpio_reg_access_t  acc;
  gpio_reg_sel_e     sel;
  logic              wr;
  logic              rd;
  logic [WIDTH-1:0]  wdata;

  assign addr          = bus.reg_addr;
  // Offsets beyond the 8-bit map must not alias onto real registers
  assign addr_in_range = ((32'(addr)) >> 8) == 32'd0;

  always_comb begin
    acc = '{we: bus.reg_we, addr: 8'(addr), wdata: bus.reg_wdata};
    sel = REG_SEL_NONE;
    if (addr_in_range) begin
      sel = gpio_decode(acc.addr);
    end
  end

  assign wr    = bus.reg_req &  acc.we;
  assign rd    = bus.reg_req & ~acc.we;
  assign wdata = acc.wdata[WIDTH-1:0];

  // ---------------- registers ----------------
  logic [WIDTH-1:0]      rise_en_q, rise_en_d;
  logic [WIDTH-1:0]      fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      irq_en_q,  irq_en_d;
  logic [WIDTH-1:0]      status_q,  status_d;
  logic [WIDTH-1:0]      w1c;
  logic [GPIO_REG_W-1:0] rdata_q,   rdata_d;
  logic                  ack_q;
  logic                  irq_q,     irq_d;

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    irq_en_d  = irq_en_q;
    w1c       = '0;
    if (wr) begin
      case (sel)
        REG_SEL_RISE_EN: rise_en_d = wdata;
        REG_SEL_FALL_EN: fall_en_d = wdata;
        REG_SEL_IRQ_EN:  irq_en_d  = wdata;
        REG_SEL_STATUS:  w1c       = wdata;
        default:         ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coinciding edge survives
    status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d    = |(status_q & irq_en_q);
  end

  // Reads sample the registers before this edge's updates take effect
  always_comb begin
    rdata_d = '0;
    if (rd) begin
      case (sel)
        REG_SEL_VALUE:   rdata_d = GPIO_REG_W'(stable);
        REG_SEL_RISE_EN: rdata_d = GPIO_REG_W'(rise_en_q);
        REG_SEL_FALL_EN: rdata_d = GPIO_REG_W'(fall_en_q);
        REG_SEL_STATUS:  rdata_d = GPIO_REG_W'(status_q);
        REG_SEL_IRQ_EN:  rdata_d = GPIO_REG_W'(irq_en_q);
        default:         rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_en_q  <= irq_en_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
      ack_q     <= bus.reg_req;
      irq_q     <= irq_d;
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign bus.reg_ack   = ack_q;
  assign gpio_value    = stable;
  assign irq           = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_edge_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_gpio_edge_capture                                        |
// | Purpose  : Self-checking bench for gpio_edge_capture: register table,  |
// |            directed latency/race sequences and a randomized phase      |
// |            checked by a cycle-level reference model.                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_gpio_edge_capture;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int AW    = 5;
  localparam int HL    = SYNC + DEB;

  localparam logic [AW-1:0] A_VALUE = 5'h00;
  localparam logic [AW-1:0] A_RISE  = 5'h04;
  localparam logic [AW-1:0] A_FALL  = 5'h08;
  localparam logic [AW-1:0] A_STAT  = 5'h0C;
  localparam logic [AW-1:0] A_IRQEN = 5'h10;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] gpio_input;
  logic [WIDTH-1:0] gpio_value;
  logic             irq;

  int n_total = 0;
  int n_bad   = 0;

  gpio_edge_capture_if #(.ADDR_W(AW)) bus ();

  gpio_edge_capture #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .ADDR_W          (AW)
  ) dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .gpio_input (gpio_input),
    .bus        (bus.slave),
    .gpio_value (gpio_value),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_in[k] holds the pin word sampled k+1 edges ago. A pin's debounced
  // value follows the synchronised samples once the last DEB of them agree.
  logic [31:0] m_in [HL];
  logic [31:0] m_stable, m_rise_en, m_fall_en, m_status, m_irq_en, m_rdata;
  logic        m_ack, m_irq;

  function automatic logic [31:0] m_debounced(input logic [31:0] cur);
    logic [31:0] all1;
    logic [31:0] all0;
    all1 = '1;
    all0 = '1;
    for (int j = 0; j < DEB; j++) begin
      all1 = all1 & m_in[SYNC-1+j];
      all0 = all0 & ~m_in[SYNC-1+j];
    end
    return all1 | (cur & ~all0);
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    case (a)
      A_VALUE: return m_stable;
      A_RISE:  return m_rise_en;
      A_FALL:  return m_fall_en;
      A_STAT:  return m_status;
      A_IRQEN: return m_irq_en;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_w1c();
    if (bus.reg_req && bus.reg_we && bus.reg_addr == A_STAT) return bus.reg_wdata;
    return 32'h0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < HL; j++) m_in[j] <= '0;
      m_stable  <= '0;
      m_rise_en <= '0;
      m_fall_en <= '0;
      m_status  <= '0;
      m_irq_en  <= '0;
      m_rdata   <= '0;
      m_ack     <= 1'b0;
      m_irq     <= 1'b0;
    end else begin
      m_in[0] <= gpio_input;
      for (int j = 1; j < HL; j++) m_in[j] <= m_in[j-1];
      m_stable <= m_debounced(m_stable);
      m_status <= (m_status & ~m_w1c())
                | (m_debounced(m_stable) & ~m_stable & m_rise_en)
                | (~m_debounced(m_stable) & m_stable & m_fall_en);
      m_irq    <= |(m_status & m_irq_en);
      m_ack    <= bus.reg_req;
      m_rdata  <= (bus.reg_req && !bus.reg_we) ? m_read(bus.reg_addr) : 32'h0;
      if (bus.reg_req && bus.reg_we) begin
        if (bus.reg_addr == A_RISE)  m_rise_en <= bus.reg_wdata;
        if (bus.reg_addr == A_FALL)  m_fall_en <= bus.reg_wdata;
        if (bus.reg_addr == A_IRQEN) m_irq_en  <= bus.reg_wdata;
      end
    end
  end

  // Scoreboard: every cycle, DUT outputs against the model
  always @(negedge clk) begin
    if (reset_n) begin
      check("scb_value", gpio_value, m_stable);
      check("scb_irq",   {31'b0, irq}, {31'b0, m_irq});
      check("scb_ack",   {31'b0, bus.reg_ack}, {31'b0, m_ack});
      check("scb_rdata", bus.reg_rdata, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue at the current negedge; result sampled at the following negedge
  task automatic reg_access(input logic we, input logic [AW-1:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata);
    bus.reg_req   = 1'b1;
    bus.reg_we    = we;
    bus.reg_addr  = addr;
    bus.reg_wdata = wdata;
    @(negedge clk);
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    check("ack", {31'b0, bus.reg_ack}, 32'h1);
    rdata = bus.reg_rdata;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    reg_access(1'b1, addr, wdata, dummy);
  endtask

  task automatic rd_check(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    reg_access(1'b0, addr, 32'h0, r);
    check(name, r, exp);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;

  vec_t        tbl [17];
  logic [AW-1:0] rnd_addr [9];

  initial begin
    tbl[0]  = '{1'b1, 5'h04, 32'hA5A5_0001, 32'h0};
    tbl[1]  = '{1'b0, 5'h04, 32'h0,         32'hA5A5_0001};
    tbl[2]  = '{1'b1, 5'h08, 32'h5A5A_0002, 32'h0};
    tbl[3]  = '{1'b0, 5'h08, 32'h0,         32'h5A5A_0002};
    tbl[4]  = '{1'b1, 5'h10, 32'h0000_FFFF, 32'h0};
    tbl[5]  = '{1'b0, 5'h10, 32'h0,         32'h0000_FFFF};
    tbl[6]  = '{1'b1, 5'h00, 32'h1234_5678, 32'h0};
    tbl[7]  = '{1'b0, 5'h00, 32'h0,         32'h0};
    tbl[8]  = '{1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b0, 5'h14, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 5'h1C, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 5'h0C, 32'hFFFF_FFFF, 32'h0};
    tbl[12] = '{1'b0, 5'h0C, 32'h0,         32'h0};
    tbl[13] = '{1'b1, 5'h04, 32'h0,         32'h0};
    tbl[14] = '{1'b1, 5'h08, 32'h0,         32'h0};
    tbl[15] = '{1'b1, 5'h10, 32'h0,         32'h0};
    tbl[16] = '{1'b0, 5'h04, 32'h0,         32'h0};
    rnd_addr[0] = 5'h00; rnd_addr[1] = 5'h04; rnd_addr[2] = 5'h08;
    rnd_addr[3] = 5'h0C; rnd_addr[4] = 5'h10; rnd_addr[5] = 5'h14;
    rnd_addr[6] = 5'h18; rnd_addr[7] = 5'h1C; rnd_addr[8] = 5'h02;
  end

  initial begin
    logic [31:0] r;
    reset_n       = 1'b0;
    gpio_input    = 32'hFFFF_FFFF;
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    tick(3);

    // ---- reset / defaults, pins held high through reset ----
    reset_n = 1'b1;
    check("rst_value", gpio_value, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rd_check("rst_rd_value", A_VALUE, 32'h0);
    rd_check("rst_rd_rise",  A_RISE,  32'h0);
    rd_check("rst_rd_fall",  A_FALL,  32'h0);
    rd_check("rst_rd_stat",  A_STAT,  32'h0);
    rd_check("rst_rd_irqen", A_IRQEN, 32'h0);
    check("value_not_early", gpio_value, 32'h0);
    tick(1);
    check("value_after_latency", gpio_value, 32'hFFFF_FFFF);
    rd_check("rst_stat_after", A_STAT, 32'h0);
    check("rst_irq_after", {31'b0, irq}, 32'h0);

    gpio_input = 32'h0;
    tick(10);

    // ---- register table ----
    for (int i = 0; i < 17; i++) begin
      reg_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, r);
      if (!tbl[i].we) check($sformatf("tbl%0d", i), r, tbl[i].exp);
    end

    // ---- rising edge to irq, then W1C ----
    wr(A_RISE, 32'h1);
    wr(A_IRQEN, 32'h1);
    gpio_input[0] = 1'b1;
    tick(5);
    check("rise_value_n5", {31'b0, gpio_value[0]}, 32'h0);
    check("rise_irq_n5", {31'b0, irq}, 32'h0);
    tick(1);
    check("rise_value_n6", {31'b0, gpio_value[0]}, 32'h1);
    check("rise_irq_n6", {31'b0, irq}, 32'h0);
    tick(1);
    check("rise_irq_n7", {31'b0, irq}, 32'h1);
    rd_check("rise_status", A_STAT, 32'h1);
    wr(A_STAT, 32'h1);
    check("w1c_irq_same", {31'b0, irq}, 32'h1);
    tick(1);
    check("w1c_irq_next", {31'b0, irq}, 32'h0);
    rd_check("w1c_status", A_STAT, 32'h0);

    // ---- glitch rejection on pin 1 ----
    wr(A_RISE, 32'h0);
    wr(A_IRQEN, 32'h0);
    wr(A_FALL, 32'h2);
    gpio_input[1] = 1'b1;
    tick(3);
    gpio_input[1] = 1'b0;
    tick(10);
    check("glitch3_value", {31'b0, gpio_value[1]}, 32'h0);
    rd_check("glitch3_status", A_STAT, 32'h0);
    gpio_input[1] = 1'b1;
    tick(4);
    gpio_input[1] = 1'b0;
    tick(2);
    check("pulse4_value_hi", {31'b0, gpio_value[1]}, 32'h1);
    tick(6);
    check("pulse4_value_lo", {31'b0, gpio_value[1]}, 32'h0);
    rd_check("pulse4_status", A_STAT, 32'h2);
    wr(A_STAT, 32'hFFFF_FFFF);
    wr(A_FALL, 32'h0);

    // ---- set-wins race on pin 2 ----
    wr(A_RISE, 32'h4);
    wr(A_IRQEN, 32'h4);
    gpio_input[2] = 1'b1;
    tick(8);
    rd_check("race_pre_status", A_STAT, 32'h4);
    gpio_input[2] = 1'b0;
    tick(10);
    gpio_input[2] = 1'b1;
    tick(5);
    wr(A_STAT, 32'h4);
    check("race_irq_a", {31'b0, irq}, 32'h1);
    tick(1);
    check("race_irq_b", {31'b0, irq}, 32'h1);
    rd_check("race_status", A_STAT, 32'h4);
    wr(A_IRQEN, 32'h0);
    wr(A_RISE, 32'h0);
    gpio_input[2] = 1'b0;
    tick(10);
    wr(A_STAT, 32'hFFFF_FFFF);

    // ---- masking and multi-pin ----
    wr(A_RISE, 32'h0000_00F0);
    wr(A_IRQEN, 32'h0000_0030);
    gpio_input[7:4] = 4'hF;
    tick(10);
    rd_check("mask_status", A_STAT, 32'h0000_00F0);
    check("mask_irq", {31'b0, irq}, 32'h1);
    wr(A_STAT, 32'h0000_0030);
    tick(1);
    check("mask_irq_clr", {31'b0, irq}, 32'h0);
    rd_check("mask_status_clr", A_STAT, 32'h0000_00C0);

    // ---- back-to-back reads ----
    bus.reg_req  = 1'b1;
    bus.reg_we   = 1'b0;
    bus.reg_addr = A_VALUE;
    @(negedge clk);
    check("b2b_ack0", {31'b0, bus.reg_ack}, 32'h1);
    check("b2b_value", bus.reg_rdata, 32'h0000_00F1);
    bus.reg_addr = 5'h14;
    @(negedge clk);
    check("b2b_ack1", {31'b0, bus.reg_ack}, 32'h1);
    check("b2b_unmapped", bus.reg_rdata, 32'h0);
    bus.reg_addr = A_RISE;
    @(negedge clk);
    check("b2b_ack2", {31'b0, bus.reg_ack}, 32'h1);
    check("b2b_rise", bus.reg_rdata, 32'h0000_00F0);
    bus.reg_req = 1'b0;
    @(negedge clk);
    check("b2b_ack_idle", {31'b0, bus.reg_ack}, 32'h0);

    // ---- reset in the middle of a debounce ----
    gpio_input[8] = 1'b1;
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_value", gpio_value, 32'h0);
    check("mid_rst_ack", {31'b0, bus.reg_ack}, 32'h0);
    tick(3);
    reset_n = 1'b1;
    wr(A_RISE, 32'h0000_0100);
    wr(A_IRQEN, 32'h0000_0100);
    tick(3);
    check("post_rst_value_n5", gpio_value, 32'h0);
    tick(1);
    check("post_rst_value_n6", gpio_value, 32'h0000_01F1);
    check("post_rst_irq_n6", {31'b0, irq}, 32'h0);
    tick(1);
    check("post_rst_irq_n7", {31'b0, irq}, 32'h1);
    rd_check("post_rst_status", A_STAT, 32'h0000_0100);

    // ---- randomized phase, checked by the scoreboard ----
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) gpio_input = gpio_input ^ ($urandom & 32'h0000_0F0F);
      bus.reg_req   = 1'($urandom_range(0, 1));
      bus.reg_we    = 1'($urandom_range(0, 1));
      bus.reg_addr  = rnd_addr[$urandom_range(0, 8)];
      bus.reg_wdata = $urandom;
      @(negedge clk);
    end
    bus.reg_req = 1'b0;
    tick(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_edge_capture.md
Name: gpio_edge_capture

Overview:
Input-side GPIO peripheral that reads the pins the firmware and external logic drive toward the MCU. It synchronises and debounces each pin, then detects rising and falling edges per pin. Detected edges are latched into sticky W1C status bits, and a single level interrupt is raised to the RISC-V core. The block sits on the MCU peripheral register bus beside the GPIO output block, with gpio_input as its pin source.

Parameters:
WIDTH, 32, number of GPIO input pins
SYNC_STAGES, 2, flip-flop synchroniser depth per pin (minimum 2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a pin change is accepted; 0 bypasses debounce
ADDR_W, 5, byte address width of the register port

Ports:
clock  input  1  system clock; the only clock
reset_n  input  1  asynchronous active-low reset
gpio_input  input  WIDTH  raw asynchronous pin inputs
reg_req  input  1  register access request, single cycle
reg_we  input  1  1 = write, 0 = read
reg_addr  input  ADDR_W  byte address, word aligned
reg_wdata  input  32  write data
reg_rdata  output  32  read data, valid when reg_ack is 1
reg_ack  output  1  one-cycle acknowledge, exactly one cycle after reg_req
gpio_value  output  WIDTH  debounced pin state
irq  output  1  level interrupt, registered

Behaviour:
- Reset is asynchronous and active-low; clock is the single clock domain.
- Reset state: all synchroniser flops 0, debounced state 0, debounce counters 0, RISE_EN/FALL_EN/STATUS/IRQ_EN 0, reg_rdata 0, reg_ack 0, irq 0.
- Synchroniser: pin change is visible at the synchroniser output SYNC_STAGES cycles after it is sampled.
- Debounce, per pin, with counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync != stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still != stable, stable <= sync and the counter clears.
  - If sync == stable, the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
  - DEBOUNCE_CYCLES=0: stable <= sync every cycle.
- Edge detect: rise = stable changed 0->1; fall = stable changed 1->0. Evaluated in the cycle stable updates.
- Status set: STATUS[i] is set on (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]), in the same edge as the stable update.
- irq <= |(STATUS & IRQ_EN), one cycle after the status change.
- Total latency, pin to irq = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (nominal, excluding sampling phase).
- Register map (32-bit words; bits above WIDTH read 0 and are ignored on write):
  - 0x00 VALUE: RO, debounced state. Writes ignored.
  - 0x04 RISE_EN: RW.
  - 0x08 FALL_EN: RW.
  - 0x0C STATUS: RO, write-1-to-clear.
  - 0x10 IRQ_EN: RW.
  - Other addresses: read 0, writes ignored, still acked.
- Register port timing: reg_ack asserts exactly one cycle after reg_req. A write takes effect on the same edge that raises reg_ack. Back-to-back requests every cycle are legal, and each is acked.
- Simultaneous W1C and new edge on the same bit: set wins, and the bit stays 1.
- A STATUS read returns the pre-update value. An edge set in the same cycle appears on the next read.
- Enabling RISE_EN/FALL_EN does not retroactively set STATUS for past edges.
- Clearing IRQ_EN deasserts irq next cycle; STATUS is retained.
- Reset mid-debounce: counters and state are forced to 0 asynchronously. After release, a pin held at 1 produces a rise edge after full latency.

Decomposition:
- Shared package gpio_pkg holds the register offset constants (GPIO_VALUE_OFS, GPIO_RISE_EN_OFS, GPIO_FALL_EN_OFS, GPIO_STATUS_OFS, GPIO_IRQ_EN_OFS) and the register-port access typedef for reuse by the GPIO output block and the bus decoder.
- One sub-module, gpio_debounce_cell: per-pin synchroniser, debounce counter, stable flop and rise/fall pulses. Instantiated WIDTH times via generate. The top level holds the registers, register port and irq.

Test Plan:
- Reset/defaults: hold reset_n=0 with gpio_input=32'hFFFF_FFFF, then release -> all registers read 0. After SYNC_STAGES+DEBOUNCE_CYCLES cycles, VALUE=32'hFFFF_FFFF, STATUS=0, irq=0.
- Rising edge interrupt: RISE_EN=1, IRQ_EN=1, drive gpio_input[0] 0->1 -> STATUS=32'h1 after 2+4 cycles and irq=1 one cycle later. Write STATUS=1 -> irq=0 next cycle.
- Glitch rejection: with FALL_EN[1]=1, pulse gpio_input[1] high for 3 cycles -> VALUE[1] stays 0 and STATUS=0. A 4-cycle pulse -> VALUE[1] toggles, and the falling edge sets STATUS[1].
- Set-wins race: time the W1C of STATUS[2] to the same edge as a new enabled rise on pin 2 -> STATUS[2] reads 1 afterwards and irq stays 1.
- Masking and multi-pin: RISE_EN=32'h0000_00F0, IRQ_EN=32'h0000_0030, raise pins 4..7 together -> STATUS=32'h0000_00F0 and irq=1. Clear bits 4,5 -> irq=0 and STATUS=32'h0000_00C0.
- Register port: back-to-back reads of 0x00, 0x14, 0x04 -> three consecutive acks, and 0x14 reads 0.
